// File: rtl/write_network.sv
// Write-back stage of the layered LDPC decoder: un-rotates one layer's APP blocks into the APP memory.
// Optional duplicate/out-of-range destination checker enabled by defining WRITE_DUPCHK_EN.
module write_network #(
    parameter int Z  = 4,
    parameter int Q  = 6,
    parameter int DC = 6,
    parameter int NB = 52
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 load_en,
    input  logic [$clog2(NB)-1:0]                load_idx,
    input  logic [Z-1:0][Q-1:0]                  load_data,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [$clog2(DC+1)-1:0]              layer_deg,
    input  logic [DC-1:0][$clog2(NB)-1:0]        col_indices,
    input  logic [DC-1:0][$clog2(Z)-1:0]         shift_values,
    input  logic [DC-1:0][Z-1:0][Q-1:0]          app_in,
    output logic [NB-1:0][Z-1:0][Q-1:0]          app_mem,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 err
);

    localparam int IW = $clog2(NB);
    localparam int DW = $clog2(DC + 1);
    localparam int SW = $clog2(Z);
    localparam logic [IW:0] NB_W = (IW + 1)'(NB);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t                        state;
    logic [DW-1:0]                 deg_q;
    logic [DW-1:0]                 k;
    logic [DC-1:0][IW-1:0]         col_q;
    logic [DC-1:0][SW-1:0]         shift_q;
    logic [DC-1:0][Z-1:0][Q-1:0]   app_q;

    logic [DW-1:0] deg_c;
    logic          load_ok;
    logic          col_ok;

    // Handshake: a layer is taken on any edge where in_valid && in_ready; in_ready is high only in IDLE.
    assign deg_c   = (layer_deg > DW'(DC)) ? DW'(DC) : layer_deg;
    assign load_ok = ({1'b0, load_idx} < NB_W);
    assign col_ok  = ({1'b0, col_q[k]} < NB_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            k        <= '0;
            deg_q    <= '0;
            col_q    <= '0;
            shift_q  <= '0;
            app_q    <= '0;
            app_mem  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (load_en && load_ok) begin
                        app_mem[load_idx] <= load_data;
                    end
                    if (in_valid && in_ready) begin
                        deg_q    <= deg_c;
                        col_q    <= col_indices;
                        shift_q  <= shift_values;
                        app_q    <= app_in;
                        k        <= '0;
                        in_ready <= 1'b0;
                        if (deg_c == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= WRITE;
                            busy  <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    // Inverse of the read-side rotation out[j] = in[(j+s) mod Z].
                    if (col_ok) begin
                        for (int j = 0; j < Z; j++) begin
                            app_mem[col_q[k]][SW'((j + int'(shift_q[k])) % Z)] <= app_q[k][j];
                        end
                    end
                    k <= k + DW'(1);
                    if (k == deg_q - DW'(1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    done     <= 1'b0;
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

`ifdef WRITE_DUPCHK_EN
    logic dup;

    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < DC; i++) begin
            if (DW'(i) < deg_c) begin
                if ({1'b0, col_indices[i]} >= NB_W) begin
                    dup = 1'b1;
                end
                for (int m = 0; m < i; m++) begin
                    if (col_indices[m] == col_indices[i]) begin
                        dup = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (state == IDLE && in_valid && in_ready && dup) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_write_network.sv
// Directed bench for write_network: reset, load port, inverse rotation, timing, clamp, duplicates, reset abort.
module tb_write_network;

    localparam int Z  = 4;
    localparam int Q  = 6;
    localparam int DC = 6;
    localparam int NB = 52;
    localparam int IW = $clog2(NB);
    localparam int DW = $clog2(DC + 1);
    localparam int SW = $clog2(Z);

`ifdef WRITE_DUPCHK_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    typedef logic [Z-1:0][Q-1:0] grp_t;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          load_en;
    logic [IW-1:0]                 load_idx;
    grp_t                          load_data;
    logic                          in_valid;
    logic                          in_ready;
    logic [DW-1:0]                 layer_deg;
    logic [DC-1:0][IW-1:0]         col_indices;
    logic [DC-1:0][SW-1:0]         shift_values;
    logic [DC-1:0][Z-1:0][Q-1:0]   app_in;
    logic [NB-1:0][Z-1:0][Q-1:0]   app_mem;
    logic [NB-1:0][Z-1:0][Q-1:0]   exp_mem;
    logic                          busy;
    logic                          done;
    logic                          err;

    int n_cmp;
    int n_bad;

    write_network #(.Z(Z), .Q(Q), .DC(DC), .NB(NB)) dut (
        .clk          (clk),
        .rst          (rst),
        .load_en      (load_en),
        .load_idx     (load_idx),
        .load_data    (load_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .layer_deg    (layer_deg),
        .col_indices  (col_indices),
        .shift_values (shift_values),
        .app_in       (app_in),
        .app_mem      (app_mem),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    function automatic grp_t grp(input int a, input int b, input int c, input int d);
        grp_t g;
        g[0] = Q'(a);
        g[1] = Q'(b);
        g[2] = Q'(c);
        g[3] = Q'(d);
        return g;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_mem(input string tag);
        int bad_g;
        bad_g = -1;
        for (int g = NB - 1; g >= 0; g--) begin
            if (app_mem[g] !== exp_mem[g]) bad_g = g;
        end
        n_cmp++;
        assert (app_mem === exp_mem) else begin
            n_bad++;
            $error("FAIL %s: app_mem group %0d observed %0h expected %0h",
                   tag, bad_g, app_mem[bad_g], exp_mem[bad_g]);
        end
    endtask

    // Reference write of one entry: lane l lands at (l + sh) mod Z, skipped when col is out of range.
    task automatic model_entry(input int col, input int sh, input grp_t d);
        if (col < NB) begin
            for (int l = 0; l < Z; l++) exp_mem[col][(l + sh) % Z] = d[l];
        end
    endtask

    task automatic scramble;
        layer_deg = DW'($urandom_range(0, 7));
        for (int i = 0; i < DC; i++) begin
            col_indices[i]  = IW'($urandom_range(0, 63));
            shift_values[i] = SW'($urandom_range(0, 3));
            for (int l = 0; l < Z; l++) app_in[i][l] = Q'($urandom_range(0, 63));
        end
    endtask

    task automatic set_full_layer;
        layer_deg = DW'(6);
        for (int e = 0; e < DC; e++) begin
            col_indices[e]  = IW'(e);
            shift_values[e] = SW'(e % 4);
            for (int l = 0; l < Z; l++) app_in[e][l] = Q'(e * 4 + l + 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        rst          = 1'b1;
        load_en      = 1'b0;
        load_idx     = '0;
        load_data    = '0;
        in_valid     = 1'b0;
        layer_deg    = '0;
        col_indices  = '0;
        shift_values = '0;
        app_in       = '0;
        exp_mem      = '0;

        // Reset held two cycles
        tick;
        tick;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk_mem("rst_mem");
        rst = 1'b0;

        // Load in IDLE, then an out-of-range load index
        load_en = 1'b1; load_idx = 7; load_data = grp(1, 2, 3, 4);
        tick;
        load_en = 1'b0;
        chk("load_7", app_mem[7], grp(1, 2, 3, 4));
        exp_mem[7] = grp(1, 2, 3, 4);
        load_en = 1'b1; load_idx = 52; load_data = grp(9, 9, 9, 9);
        tick;
        load_en = 1'b0;
        chk_mem("load_oob_ignored");

        // Inverse rotation, degree 1, with loads attempted during WRITE and DONE
        in_valid = 1'b1; layer_deg = 1; col_indices[0] = 3; shift_values[0] = 1;
        app_in[0] = grp(10, 11, 12, 13);
        chk("rot_ready_accept", in_ready, 1);
        tick;                                   // accept+1
        in_valid = 1'b0;
        scramble();
        chk("rot_busy_a1", busy, 1);
        chk("rot_ready_a1", in_ready, 0);
        chk("rot_done_a1", done, 0);
        load_en = 1'b1; load_idx = 7; load_data = grp(20, 21, 22, 23);
        tick;                                   // accept+2
        chk("rot_done_a2", done, 1);
        chk("rot_busy_a2", busy, 0);
        chk("rot_ready_a2", in_ready, 0);
        chk("rot_mem3", app_mem[3], grp(13, 10, 11, 12));
        chk("rot_load_in_write", app_mem[7], grp(1, 2, 3, 4));
        exp_mem[3] = grp(13, 10, 11, 12);
        tick;                                   // accept+3, load during DONE ignored
        load_en = 1'b0;
        chk("rot_ready_a3", in_ready, 1);
        chk("rot_done_a3", done, 0);
        chk_mem("rot_mem_all");

        // Full layer with in_valid held high: second identical layer accepted at accept+8
        set_full_layer();
        for (int e = 0; e < DC; e++) model_entry(e, e % 4, app_in[e]);
        in_valid = 1'b1;
        tick;                                   // accept+1
        for (int c = 1; c <= 7; c++) begin
            chk($sformatf("full_ready_low_%0d", c), in_ready, 0);
            chk($sformatf("full_done_%0d", c), done, (c == 7) ? 1 : 0);
            if (c == 7) chk_mem("full_mem");
            tick;
        end
        chk("full_second_accept_ready", in_ready, 1);
        tick;                                   // second accept+1
        in_valid = 1'b0;
        repeat (6) tick;                        // second accept+7
        chk("full2_done", done, 1);
        chk_mem("full2_mem");
        tick;

        // Degree 0: no memory change, done at accept+1
        in_valid = 1'b1; layer_deg = 0; col_indices[0] = 3; shift_values[0] = 0;
        app_in[0] = grp(63, 63, 63, 63);
        tick;
        in_valid = 1'b0;
        chk("deg0_done", done, 1);
        chk("deg0_busy", busy, 0);
        chk_mem("deg0_mem");
        tick;
        chk("deg0_ready_back", in_ready, 1);

        // Degree 7 clamps to 6 writes
        layer_deg = 7;
        for (int e = 0; e < DC; e++) begin
            col_indices[e]  = IW'(10 + e);
            shift_values[e] = 3;
            for (int l = 0; l < Z; l++) app_in[e][l] = Q'(e * 8 + l);
            model_entry(10 + e, 3, app_in[e]);
        end
        in_valid = 1'b1;
        tick;                                   // accept+1
        in_valid = 1'b0;
        scramble();
        repeat (5) tick;                        // accept+6
        chk("clamp_done_a6", done, 0);
        chk("clamp_busy_a6", busy, 1);
        tick;                                   // accept+7
        chk("clamp_done_a7", done, 1);
        chk_mem("clamp_mem");
        tick;

        // Duplicate destination: higher entry wins; unused entries beyond deg are not written
        layer_deg = 3;
        col_indices = '0;
        shift_values = '0;
        col_indices[0] = 5; col_indices[1] = 9; col_indices[2] = 5;
        col_indices[3] = 20; col_indices[4] = 20; col_indices[5] = 20;
        app_in[0] = grp(40, 41, 42, 43);
        app_in[1] = grp(50, 51, 52, 53);
        app_in[2] = grp(60, 61, 62, 63);
        app_in[3] = grp(7, 7, 7, 7);
        app_in[4] = grp(7, 7, 7, 7);
        app_in[5] = grp(7, 7, 7, 7);
        in_valid = 1'b1;
        chk("dup_err_before", err, 0);
        tick;                                   // accept+1
        in_valid = 1'b0;
        chk("dup_err_a1", err, ERR_ON);
        repeat (3) tick;                        // accept+4
        chk("dup_done", done, 1);
        chk("dup_mem5", app_mem[5], grp(60, 61, 62, 63));
        exp_mem[5] = grp(60, 61, 62, 63);
        exp_mem[9] = grp(50, 51, 52, 53);
        chk_mem("dup_mem");
        tick;

        // Load and accept in the same cycle; entry 1 targets an out-of-range group
        load_en = 1'b1; load_idx = 20; load_data = grp(5, 6, 7, 8);
        in_valid = 1'b1; layer_deg = 2;
        col_indices[0] = 20; shift_values[0] = 2; app_in[0] = grp(30, 31, 32, 33);
        col_indices[1] = 60; shift_values[1] = 0; app_in[1] = grp(1, 1, 1, 1);
        tick;                                   // accept+1
        load_en = 1'b0; in_valid = 1'b0;
        chk("same_cycle_load", app_mem[20], grp(5, 6, 7, 8));
        tick;                                   // accept+2
        chk("same_cycle_layer_wins", app_mem[20], grp(32, 33, 30, 31));
        tick;                                   // accept+3
        chk("oob_done", done, 1);
        exp_mem[20] = grp(32, 33, 30, 31);
        chk_mem("oob_mem");
        chk("err_sticky", err, ERR_ON);
        tick;

        // Reset in the middle of a layer
        set_full_layer();
        in_valid = 1'b1;
        tick;                                   // accept+1
        in_valid = 1'b0;
        tick;
        tick;
        rst = 1'b1;
        tick;
        chk("midrst_ready", in_ready, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_err", err, 0);
        exp_mem = '0;
        chk_mem("midrst_mem");
        rst = 1'b0;
        tick;
        chk("midrst_no_done", done, 0);
        tick;
        chk("midrst_no_done2", done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/write_network.md
# write_network

Write-back stage of the layered LDPC decoder. Accepts one layer's updated APP blocks from the check-node/LBS path, undoes each block's cyclic shift, and commits the blocks one VN group per cycle into the APP memory it owns. The registered memory image drives `read_network`, closing the decode loop. It also provides the initial channel-LLR load port.

## Interface

**Parameters**
- `Z`, 4: lifting size.
- `Q`, 6: APP value width.
- `DC`, 6: maximum VN groups per layer.
- `NB`, 52: total VN groups.

**Ports**
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `load_en`  in  1  channel-LLR load strobe.
- `load_idx`  in  `$clog2(NB)`  VN group to load.
- `load_data`  in  `[Z][Q]`  channel LLRs for that group.
- `in_valid`  in  1  layer update offered.
- `in_ready`  out  1  block can accept a layer.
- `layer_deg`  in  `$clog2(DC+1)`  number of valid entries, 0..DC.
- `col_indices`  in  `[DC][$clog2(NB)]`  destination VN groups.
- `shift_values`  in  `[DC][$clog2(Z)]`  shifts applied on the read side.
- `app_in`  in  `[DC][Z][Q]`  updated, still-rotated APP values.
- `app_mem`  out  `[NB][Z][Q]`  registered APP memory, feeds `read_network`.
- `busy`  out  1  layer write in progress.
- `done`  out  1  one-cycle pulse when a layer is committed.
- `err`  out  1  sticky error flag (only under `WRITE_DUPCHK_EN`, else tied 0).

## Operation

- **FSM states.** IDLE, WRITE, DONE.
- **IDLE.**
  - `in_ready=1`.
  - On `in_valid && in_ready`, capture `layer_deg` (clamped to DC), `col_indices`, `shift_values` and `app_in` into holding registers. Clear write counter `k`.
  - If the clamped degree is 0, go to DONE. Otherwise go to WRITE.
- **WRITE.**
  - `in_ready=0`, `busy=1`.
  - Each cycle write held entry `k` as `app_mem[col[k]][(j+shift[k]) mod Z] <= app_held[k][j]` for all j. This is the inverse of the read-side rotation `out[j]=in[(j+s) mod Z]`.
  - Increment `k`. When `k==deg-1` is written, go to DONE.
- **DONE.**
  - `done=1` and `busy=0` for exactly one cycle, then go to IDLE.
- **Load port.**
  - `load_en` is honoured only in IDLE: `app_mem[load_idx] <= load_data` unrotated.
  - In WRITE and DONE it is ignored.
  - `load_idx >= NB` is ignored.
- **Simultaneous events.**
  - Load and layer accept in the same IDLE cycle: the load commits that cycle, and layer writes follow, so the layer wins on overlap.
  - Duplicate column indices within a layer: the higher entry index wins (sequential order).
- **Out-of-range destinations.** `col[k] >= NB` suppresses that entry's write, but the counter still advances.
- **Shift range.** Shift values are taken mod Z.
- **Memory hold.** `app_mem` holds its value except on the writes listed above.

## Timing

- **Reset values.**
  - State IDLE, so `in_ready=1` while and after `rst` is held.
  - `app_mem` all zeros; `busy=0`, `done=0`, `err=0`, `k=0`.
- **Reset mid-layer.** Aborts the layer. Entries already written are overwritten by the zero reset, and no `done` is produced.
- **Latency.**
  - Accept on edge 0; entries are written on edges 1..deg.
  - `done` is high in the cycle after edge deg. IDLE resumes one cycle later.
  - Layer period is deg+2 cycles; a degree-0 layer takes 2 cycles.
- **Visibility.** `app_mem` reflects a write in the cycle after the edge that performs it.
- **Input stability.** Inputs need only be valid in the accept cycle, because everything is captured.

## Configuration

- **`WRITE_DUPCHK_EN` defined.**
  - On accept, compare all pairs of the first deg `col_indices` and range-check each against NB.
  - Any duplicate or out-of-range entry sets `err` on the accept edge + 1.
  - `err` is sticky until `rst`. Write behaviour is unchanged.
- **Not defined.** No checker logic; `err` is constant 0.

## Test plan

(Z=4, Q=6, DC=6, NB=52.)

- **Reset.**
  - Stimulus: hold `rst` 2 cycles.
  - Response: `app_mem` all 0, `in_ready=1`, `busy=0`, `done=0`, `err=0`.
- **Load then read back.**
  - Stimulus: `load_en`, `load_idx=7`, `load_data={1,2,3,4}` in IDLE.
  - Response: next cycle `app_mem[7]={1,2,3,4}`. The same load issued during WRITE leaves `app_mem[7]` unchanged.
- **Inverse rotation.**
  - Stimulus: `layer_deg=1`, `col[0]=3`, `shift[0]=1`, `app_in[0]={10,11,12,13}`.
  - Response: `app_mem[3]={13,10,11,12}`.
  - Timing: `busy` high 1 cycle, `done` pulses at accept+2, `in_ready` returns at accept+3.
- **Full layer with backpressure.**
  - Stimulus: `layer_deg=6`, cols 0..5; keep `in_valid` high.
  - Response: `in_ready` stays 0 for 7 cycles, `done` at accept+7, and the second layer is accepted at accept+8.
- **Degree 0 and clamp.**
  - Stimulus: `layer_deg=0`, then separately `layer_deg=7`.
  - Response: first case, no memory change, `done` at accept+1. Second case, treated as 6 writes.
- **Duplicate, with `WRITE_DUPCHK_EN`.**
  - Stimulus: `col={5,9,5}`, `layer_deg=3`.
  - Response: `app_mem[5]` holds entry 2's data and `err=1` from accept+1 until `rst`. Without the macro, `err` stays 0.
